// File: rtl/hc166_pkg.sv
// Shared constants for the HC166 parallel-in/serial-out shift register:
// register width and the D-pin to register-bit ordering.
package hc166_pkg;

  localparam int WIDTH = 8;

  typedef logic [WIDTH-1:0] reg_t;

  // D0..D7 arrive on pins 2,3,4,5,10,11,12,14; D0 lands in bit 0, D7 in bit 7.
  function automatic reg_t pack_d(
    input logic d0,
    input logic d1,
    input logic d2,
    input logic d3,
    input logic d4,
    input logic d5,
    input logic d6,
    input logic d7
  );
    return {d7, d6, d5, d4, d3, d2, d1, d0};
  endfunction

endpackage

// File: rtl/hc166.sv
// 74HC166-style 8-bit PISO shift register; load and shift both update on the p7 rising edge,
// D7 is visible on p13 right after the loading edge, p9 clears the register asynchronously.
module hc166
  import hc166_pkg::*;
(
  input  logic p1,
  input  logic p2,
  input  logic p3,
  input  logic p4,
  input  logic p5,
  input  logic p6,
  input  logic p7,
  input  logic p9,
  input  logic p10,
  input  logic p11,
  input  logic p12,
  input  logic p14,
  input  logic p15,
  output logic p13
);

  // Power-up value matches the cleared state so p13 is low before any reset.
  reg_t q = '0;
  reg_t d;

  assign d = pack_d(p2, p3, p4, p5, p10, p11, p12, p14);

  // Hold (p6 high) outranks both load and shift.
  always_ff @(posedge p7 or negedge p9) begin
    if (!p9) begin
      q <= '0;
    end else if (!p6) begin
      if (!p15) begin
        q <= d;
      end else begin
        q <= {q[WIDTH-2:0], p1};
      end
    end
  end

  assign p13 = q[WIDTH-1];

endmodule

// File: tb/tb_hc166.sv
// Bench for hc166: directed vector table, reset/cascade sequences, and a randomized run
// against an arithmetic model of the register contents.
module tb_hc166;
  import hc166_pkg::*;

  logic       clk = 1'b0;
  logic       mr  = 1'b1;
  logic       pe  = 1'b1;
  logic       ce  = 1'b1;
  logic       ds  = 1'b0;
  logic [7:0] d   = 8'h00;
  logic [7:0] d2  = 8'h00;
  logic       q7;
  logic       q7_2;

  int checks = 0;
  int errors = 0;

  initial forever #5 clk = ~clk;

  hc166 u1 (
    .p1(ds), .p2(d[0]), .p3(d[1]), .p4(d[2]), .p5(d[3]),
    .p6(ce), .p7(clk), .p9(mr),
    .p10(d[4]), .p11(d[5]), .p12(d[6]), .p14(d[7]),
    .p15(pe), .p13(q7)
  );

  // Second stage of a cascade: fed from u1's serial output.
  hc166 u2 (
    .p1(q7), .p2(d2[0]), .p3(d2[1]), .p4(d2[2]), .p5(d2[3]),
    .p6(ce), .p7(clk), .p9(mr),
    .p10(d2[4]), .p11(d2[5]), .p12(d2[6]), .p14(d2[7]),
    .p15(pe), .p13(q7_2)
  );

  typedef struct {
    logic       pe;
    logic       ce;
    logic       ds;
    logic [7:0] d;
    logic       exp;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic pe_v, input logic ce_v, input logic ds_v,
                              input logic [7:0] d_v, input logic exp_v);
    vec_t v;
    v.pe = pe_v; v.ce = ce_v; v.ds = ds_v; v.d = d_v; v.exp = exp_v;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  // Advance past the next rising edge; leaves time at edge+1.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    #2 mr = 1'b0;
    #2 mr = 1'b1;
  endtask

  // Read the whole register out through p13 (current bit, then 7 shifts).
  task automatic drain(input string name, input logic [7:0] exp);
    logic [7:0] got;
    pe = 1'b1; ce = 1'b0; ds = 1'b0;
    got[7] = q7;
    for (int i = 6; i >= 0; i--) begin
      step();
      got[i] = q7;
    end
    check(name, 16'(got), 16'(exp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int m;
    logic [15:0] bits;

    // Power-up state before any reset or edge.
    #1;
    check("powerup_u1", 16'(q7), 16'h0);
    check("powerup_u2", 16'(q7_2), 16'h0);

    // Async reset with no clock activity, from a preloaded FF.
    pe = 1'b0; ce = 1'b0; d = 8'hFF;
    step();
    check("preload_ff", 16'(q7), 16'h1);
    #2 mr = 1'b0;
    #1 check("async_clear", 16'(q7), 16'h0);
    step();
    check("edge_ignored_in_reset_a", 16'(q7), 16'h0);
    step();
    check("edge_ignored_in_reset_b", 16'(q7), 16'h0);
    #2 mr = 1'b1;
    #1 check("release_no_change", 16'(q7), 16'h0);
    step();
    check("first_edge_after_release", 16'(q7), 16'h1);
    pulse_reset();

    // Directed vectors, starting from Q=00.
    add(0, 0, 0, 8'hA5, 1);
    add(1, 0, 0, 8'h00, 0); add(1, 0, 0, 8'h00, 1); add(1, 0, 0, 8'h00, 0);
    add(1, 0, 0, 8'h00, 0); add(1, 0, 0, 8'h00, 1); add(1, 0, 0, 8'h00, 0);
    add(1, 0, 0, 8'h00, 1);
    add(1, 0, 0, 8'h00, 0);
    add(0, 0, 0, 8'h81, 1);
    add(1, 0, 0, 8'h00, 0); add(1, 0, 0, 8'h00, 0);
    add(0, 1, 0, 8'hFF, 0); add(0, 1, 1, 8'hFF, 0); add(0, 1, 0, 8'hFF, 0);
    add(1, 1, 1, 8'h00, 0); add(1, 1, 1, 8'h00, 0);
    add(1, 0, 0, 8'h00, 0); add(1, 0, 0, 8'h00, 0); add(1, 0, 0, 8'h00, 0);
    add(1, 0, 0, 8'h00, 0); add(1, 0, 0, 8'h00, 1);
    add(1, 0, 0, 8'h00, 0);
    for (int i = 0; i < 7; i++) add(1, 0, 1, 8'h00, 0);
    add(1, 0, 1, 8'h00, 1);
    for (int i = 0; i < vecs.size(); i++) begin
      pe = vecs[i].pe; ce = vecs[i].ce; ds = vecs[i].ds; d = vecs[i].d;
      step();
      check($sformatf("vec%0d", i), 16'(q7), 16'(vecs[i].exp));
    end

    // Reset in the middle of a shift run, released mid-cycle.
    pulse_reset();
    pe = 1'b0; ce = 1'b0; d = 8'hFF;
    step();
    pe = 1'b1; ds = 1'b0;
    step(); step(); step();
    check("shifted_f8", 16'(q7), 16'h1);
    ds = 1'b1;
    #2 mr = 1'b0;
    #1 check("mid_reset_clear", 16'(q7), 16'h0);
    step();
    check("mid_reset_edge_ignored", 16'(q7), 16'h0);
    #2 mr = 1'b1;
    #1 check("mid_release_no_change", 16'(q7), 16'h0);
    step();
    check("post_release_shift", 16'(q7), 16'h0);
    drain("post_release_q01", 8'h01);

    // Reset falling in the same timestep as a load edge.
    pe = 1'b0; ce = 1'b0; d = 8'hFF;
    @(posedge clk);
    mr = 1'b0;
    #1 check("simul_reset_wins", 16'(q7), 16'h0);
    #1 mr = 1'b1;
    drain("simul_q00", 8'h00);

    // Two-stage cascade.
    pulse_reset();
    pe = 1'b0; ce = 1'b0; d = 8'h0F; d2 = 8'hF0;
    step();
    pe = 1'b1; ds = 1'b0;
    bits = 16'h0;
    for (int i = 0; i < 16; i++) begin
      bits[15-i] = q7_2;
      step();
    end
    check("cascade_stream", bits, 16'hF00F);
    check("cascade_after16", 16'(q7_2), 16'h0);

    // Randomized run against the byte-level model.
    pulse_reset();
    m = 0;
    for (int it = 0; it < 400; it++) begin
      pe = 1'($urandom_range(0, 1));
      ce = 1'($urandom_range(0, 3) == 0);
      ds = 1'($urandom_range(0, 1));
      d  = 8'($urandom);
      if ($urandom_range(0, 19) == 0) begin
        #1 mr = 1'b0;
        m = 0;
        #1 check("rnd_async_clear", 16'(q7), 16'h0);
        step();
        check("rnd_reset_edge", 16'(q7), 16'h0);
        #1 mr = 1'b1;
        #1 check("rnd_release", 16'(q7), 16'h0);
      end else begin
        step();
        if (!ce) begin
          if (!pe) m = int'(d);
          else     m = (m * 2 + int'(ds)) % 256;
        end
        check($sformatf("rnd%0d", it), 16'(q7), 16'(m >= 128));
        // Input activity between edges must not disturb the register.
        pe = 1'($urandom_range(0, 1));
        ce = 1'($urandom_range(0, 1));
        ds = 1'($urandom_range(0, 1));
        d  = 8'($urandom);
        #1 check($sformatf("rnd_mid%0d", it), 16'(q7), 16'(m >= 128));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hc166.md
HC166 -- requirements
Module: hc166

8-bit parallel-in/serial-out shift register, 74HC166 pin-compatible; transmit-side counterpart to the flip-flop/capture parts in the component set.

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset, with ports named by package pin number as in the rest of the component set.
REQ-002 p7   input   1  CP: clock; all register updates occur on its rising edge.
REQ-003 p9   input   1  MR: asynchronous master reset, active low.
REQ-004 p15  input   1  PE: parallel enable, active low (0 = load, 1 = shift).
REQ-005 p6   input   1  CE: clock enable, active low (1 = hold).
REQ-006 p1   input   1  DS: serial data input, shifted into stage 0.
REQ-007 p2,p3,p4,p5,p10,p11,p12,p14  input  1 each  D0..D7: parallel data, in that order.
REQ-008 p13  output 1  Q7: serial output, driven directly by stage 7 of the register.
REQ-009 Pins 8 (GND) and 16 (VCC) SHALL NOT be ports.

Function
REQ-010 The internal state SHALL be an 8-bit register Q[7:0]; p13 SHALL equal Q[7] at all times.
REQ-011 On a p7 rising edge with p9=1 and p6=1, Q SHALL hold.
REQ-012 On a p7 rising edge with p9=1, p6=0 and p15=0, Q[n] SHALL load Dn for n=0..7 (synchronous load).
REQ-013 On a p7 rising edge with p9=1, p6=0 and p15=1, the register SHALL shift: Q[0]<=p1, Q[n]<=Q[n-1] for n=1..7.
REQ-014 Load-to-first-bit latency SHALL be 0 edges: D7 appears on p13 immediately after the loading edge. D6..D0 then appear on successive shift edges.
REQ-015 A byte SHALL be fully serialized after 1 load edge plus 7 shift edges. After 8 shift edges, p13 SHALL present the first bit shifted in on p1 (cascade behaviour).
REQ-016 p15 and p6 SHALL be sampled only at the p7 rising edge. Changes between edges SHALL have no effect.
REQ-017 p6 is a synchronous enable in this model, not OR-gated into the clock. Hazard-free p6 timing (change only while p7 is high) is the board designer's responsibility.
REQ-018 Hold (p6=1) SHALL take priority over both load and shift.
REQ-019 Reset-mid-shift: if p9 falls at any time, Q SHALL clear immediately, regardless of p7, p6 or p15.
REQ-020 While p9=0, p7 edges SHALL be ignored.
REQ-021 Release of p9 SHALL NOT itself modify Q. The first update SHALL occur on the next p7 rising edge with p9=1.
REQ-022 p9=0 coincident with a p7 rising edge: reset SHALL win.

Reset
REQ-023 Asynchronous reset (p9=0) SHALL set Q=8'h00 and p13=0.
REQ-024 Power-up (simulation initial) value of Q SHALL be 8'h00, so p13=0 before any reset.
REQ-025 No other state exists.

Structure
REQ-026 A shared component package SHALL hold the register width constant (8) and the D-pin-to-bit mapping order.
REQ-027 No sub-module is natural. The block SHALL be a single module with one always block for Q and a continuous assignment for p13.
REQ-028 Cascade SHALL be achieved by wiring one instance's p13 to the next instance's p1 at board level, not inside the module.

Verification
REQ-029 Reset: p9=0 pulse with no p7 activity, then Q preloaded 8'hFF -> p13=0 immediately on p9 fall, before any edge.
REQ-030 Load/shift: D=8'hA5, p6=0, p15=0, one edge; then p15=1, p1=0, seven edges -> p13 sequence 1,0,1,0,0,1,0,1; eighth edge -> p13=0.
REQ-031 Hold: load 8'h81, shift 2 edges, then p6=1 for 5 edges -> p13 stays at Q[7] of the shifted value (0); p6=0 resumes shifting with no lost bit.
REQ-032 Cascade: two instances, U1.p13->U2.p1, load U1=8'h0F, U2=8'hF0, 16 shift edges -> U2.p13 emits 1,1,1,1,0,0,0,0,0,0,0,0,1,1,1,1.
REQ-033 Reset mid-operation: load 8'hFF, shift 3, assert p9 between edges -> p13=0 at once; release p9 mid-cycle -> no change until next edge; the next shift edge with p1=1 gives Q=8'h01, p13=0.
REQ-034 Simultaneity: p9 falls in the same timestep as a load edge with D=8'hFF -> Q=8'h00.
